uart_tx_param: RTL

Parametrised UART transmitter and the successor to the fixed 8-bit, one-bit-per-clock serialiser.
- Adds a valid/ready handshake on the input.
- Adds a programmable baud divider, configurable data width and bit order, optional parity, and one or two stop bits.
- Sits between a byte-producing controller and the serial pin; output O idles high.

---
 rtl/uart_tx_param.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input, programmable baud divider,
// 5..9 data bits in either order, optional even/odd parity, one or two stop bits.
module uart_tx_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int MSB_FIRST    = 1,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESET,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic                  O,
    output logic                  busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_WIDTH - 1);
    localparam logic              STOP_LAST  = (STOP_BITS == 2);
    localparam logic              HAS_PARITY = (PARITY != 0);
    localparam logic              ODD_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic                  r_stop;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic                  r_o;

    state_t                w_state_next;
    logic [BAUD_W-1:0]     w_baud_next;
    logic [BIT_W-1:0]      w_bit_next;
    logic                  w_stop_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_parity_next;
    logic                  w_o_next;
    logic                  w_baud_end;
    logic [BAUD_W-1:0]     w_baud_inc;
    logic [DATA_WIDTH-1:0] w_shift_adv;
    logic                  w_data_parity;
    logic                  w_tx_bit;

    assign w_baud_end    = (r_baud == BAUD_LAST);
    assign w_baud_inc    = w_baud_end ? '0 : r_baud + BAUD_W'(1);
    assign w_data_parity = ODD_PARITY ? ~(^data) : (^data);

    // The bit on the line always sits at the same end of the shift register;
    // advancing to the next data bit shifts it towards that end.
    assign w_shift_adv = (MSB_FIRST != 0) ? {r_shift[DATA_WIDTH-2:0], 1'b0}
                                          : {1'b0, r_shift[DATA_WIDTH-1:1]};
    assign w_tx_bit    = (MSB_FIRST != 0) ? w_shift_next[DATA_WIDTH-1]
                                          : w_shift_next[0];

    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = r_baud;
        w_bit_next    = r_bit;
        w_stop_next   = r_stop;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (valid) begin
                    w_state_next  = S_START;
                    w_shift_next  = data;
                    w_parity_next = w_data_parity;
                    w_bit_next    = '0;
                    w_stop_next   = 1'b0;
                end
            end
            S_START: begin
                w_baud_next = w_baud_inc;
                if (w_baud_end) begin
                    w_state_next = S_DATA;
                    w_bit_next   = BIT_LAST;
                end
            end
            S_DATA: begin
                w_baud_next = w_baud_inc;
                if (w_baud_end) begin
                    if (r_bit == '0) begin
                        w_state_next = HAS_PARITY ? S_PARITY : S_STOP;
                        w_stop_next  = 1'b0;
                    end else begin
                        w_bit_next   = r_bit - BIT_W'(1);
                        w_shift_next = w_shift_adv;
                    end
                end
            end
            S_PARITY: begin
                w_baud_next = w_baud_inc;
                if (w_baud_end) begin
                    w_state_next = S_STOP;
                    w_stop_next  = 1'b0;
                end
            end
            S_STOP: begin
                w_baud_next = w_baud_inc;
                if (w_baud_end) begin
                    if (r_stop == STOP_LAST) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_next = r_stop + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
            end
        endcase
    end

    // O is registered from the next state so the start bit appears the cycle after accept.
    always_comb begin
        w_o_next = 1'b1;
        case (w_state_next)
            S_START:  w_o_next = 1'b0;
            S_DATA:   w_o_next = w_tx_bit;
            S_PARITY: w_o_next = w_parity_next;
            default:  w_o_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_stop   <= 1'b0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_o      <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_baud   <= w_baud_next;
            r_bit    <= w_bit_next;
            r_stop   <= w_stop_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_o      <= w_o_next;
        end
    end

    assign ready = (r_state == S_IDLE);
    assign busy  = (r_state != S_IDLE);
    assign O     = r_o;

endmodule
